gcd_engine: RTL
===============

Name: gcd_engine

Overview:
- Parametrised successor to the team's 8-bit subtractive GCD controller: unsigned GCD of two WIDTH-bit operands using the binary (Stein) algorithm, one shift or one subtract per clock.
- Operands may arrive in any order (a<b allowed), and either or both may be zero.
- Operand capture is a single valid/ready handshake; the result is held until acknowledged.
- Also reports the compute cycle count, for performance tracking in the arithmetic co-processor datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 6, width of cycle counter; must hold 4*WIDTH+2 (6 for WIDTH=8, 7 for WIDTH=16)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  a/b valid this cycle
in_ready  output  1  engine idle, operands accepted when in_valid&in_ready
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
out_valid  output  1  result valid, held until out_ack
out_ack  input  1  consumer takes result when out_valid&out_ack
out  output  WIDTH  gcd(a,b)
zero_in  output  1  with out_valid: at least one operand was zero
cycles  output  CNT_W  FACTOR+REDUCE cycles used for this result

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out=0, zero_in=0, cycles=0; internal x,y,k cleared.
- Internal regs: x,y (WIDTH), k (shift count, $clog2(WIDTH)+1 bits), cnt (CNT_W).
- IDLE: in_ready=1. On the accept edge, latch x=a, y=b, k=0, cnt=0.
  - If a==0 or b==0: go DONE, out=a|b, zero_in=1. gcd(0,0)=0.
  - Else: go FACTOR, zero_in=0.
- FACTOR, one cycle each, cnt++ every cycle:
  - If x[0]==0 and y[0]==0: x>>=1, y>>=1, k++.
  - Else: no data change, go REDUCE.
- REDUCE, one action per cycle, cnt++ every cycle, first match wins:
  - x even: x>>=1.
  - Else y even: y>>=1.
  - Else x==y: out=x<<k, go DONE.
  - Else x>y: x=x-y.
  - Else: y=y-x.
- DONE: out_valid=1; out, zero_in and cycles=cnt held stable.
  - On out_ack: out_valid=0 next cycle, go IDLE. out keeps its last value.
  - out_ack while out_valid=0 is ignored.
- Timing:
  - in_ready=0 in FACTOR, REDUCE and DONE; in_valid is ignored there and a/b may change freely.
  - Zero operand: out_valid rises on the clock after accept.
  - Non-zero operands: out_valid rises (cycles+1) clocks after accept.
  - Worst case cycles <= 4*WIDTH+2.
- No back-to-back overlap: the next accept is earliest in the cycle after the ack.
- Arithmetic: subtraction never underflows (larger minus smaller). x<<k never overflows (k only counts common factors of 2 already present).
- Reset asserted mid-computation or with out_valid=1 aborts immediately; the pending result is lost and nothing is emitted after reset release.

Test Plan:
- WIDTH=8: a=30, b=7 -> out=1, zero_in=0, cycles=11; out_valid 12 clocks after accept.
- WIDTH=8: a=5, b=15 (a<b) -> out=5, cycles=4. Repeat with a=15, b=5 -> same out and cycles.
- WIDTH=8: a=12, b=8 -> out=4, cycles=7. Hold out_ack=0 for 20 clocks -> out_valid, out and cycles stable, in_ready=0. Pulse out_ack -> in_ready=1 next cycle.
- WIDTH=8: a=0, b=9 -> out=9, zero_in=1, cycles=0, out_valid 1 clock after accept. a=0, b=0 -> out=0, zero_in=1.
- WIDTH=16, CNT_W=7: a=b=16'h8000 -> out=16'h8000, cycles=17. Also a=16'hFFFF, b=1 -> out=1, cycles <= 66.
- Assert rst mid-REDUCE on a=30, b=7 -> in_ready=1, out_valid=0, out=0 immediately. No out_valid after release. Next accept of a=12, b=8 -> out=4.

Source files
------------

// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine: one shift or subtract per clock, valid/ready
// operand capture, result held until acknowledged, with a compute-cycle count.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out,
  output logic             zero_in,
  output logic [CNT_W-1:0] cycles
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FACTOR = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [KW-1:0]    k_r;
  logic [CNT_W-1:0] cnt_r;

  // Restore the common power of two removed during FACTOR.
  function automatic logic [WIDTH-1:0] restore_pow2(input logic [WIDTH-1:0] v,
                                                     input logic [KW-1:0]    sh);
    return WIDTH'(v << sh);
  endfunction

  // Engine state machine with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      x_r       <= '0;
      y_r       <= '0;
      k_r       <= '0;
      cnt_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      zero_in   <= 1'b0;
      cycles    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r      <= a;
            y_r      <= b;
            k_r      <= '0;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            if ((a == '0) || (b == '0)) begin
              state_r <= DONE;
              out     <= a | b;
              zero_in <= 1'b1;
              cycles  <= '0;
            end else begin
              state_r <= FACTOR;
              zero_in <= 1'b0;
            end
          end
        end
        FACTOR: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (!x_r[0] && !y_r[0]) begin
            x_r <= x_r >> 1;
            y_r <= y_r >> 1;
            k_r <= k_r + KW'(1);
          end else begin
            state_r <= REDUCE;
          end
        end
        REDUCE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (!x_r[0]) begin
            x_r <= x_r >> 1;
          end else if (!y_r[0]) begin
            y_r <= y_r >> 1;
          end else if (x_r == y_r) begin
            out     <= restore_pow2(x_r, k_r);
            cycles  <= cnt_r + CNT_W'(1);
            state_r <= DONE;
          end else if (x_r > y_r) begin
            x_r <= x_r - y_r;
          end else begin
            y_r <= y_r - x_r;
          end
        end
        DONE: begin
          // out_valid rises one clock after entering DONE; ack only counts once it is up.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ack) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
